skew_align: RTL and testbench

//  Parametrised multi-channel deskew aligner. Each of CH input lanes passes through its own

---
 rtl/skew_align.sv | 200 ++++++++++++++++++++
 tb/tb_skew_align.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_align.sv
// -----------------------------------------------------------------------------
// skew_align
//   Multi-lane deskew aligner. Every lane runs through its own programmable
//   delay line (0..MAXD cycles) so that lanes arriving with relative skew
//   leave the block aligned. A calibration FSM times a common marker edge
//   (bit 0 of each lane) on all lanes and then loads the per-lane delays
//   that line the lanes up with the latest one.
//
//   Ports
//     clk        rising-edge clock for all logic
//     rst        synchronous active-high reset (datapath and control)
//     din        lane data, lane i = din[i*W +: W]
//     cal_start  one-cycle calibration request, accepted only in IDLE
//     dout       aligned lane data, lane i = dout[i*W +: W]
//     cal_busy   high while the FSM is in ARM, WAIT or CALC
//     cal_done   one-cycle pulse while the FSM is in DONE
//     cal_err    sticky error flag, set in DONE, cleared by the next
//                accepted cal_start
//     skew_out   currently applied delay of each lane, lane i at [i*DW +: DW]
//
//   Latency through lane i is delay_i+1 cycles. The output register picks
//   either din (delay 0) or tap k-1 (delay k), which makes it equivalent to
//   reading stage k of a MAXD+1 stage line whose stage 0 is din registered.
// -----------------------------------------------------------------------------
module skew_align #(
   parameter int  CH      = 4,
   parameter int  W       = 1,
   parameter int  MAXD    = 7,
   parameter int  TIMEOUT = 255,
   localparam int DW      = $clog2(MAXD + 1),
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH*W-1:0]   din,
   input  logic              cal_start,
   output logic [CH*W-1:0]   dout,
   output logic              cal_busy,
   output logic              cal_done,
   output logic              cal_err,
   output logic [CH*DW-1:0]  skew_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_CALC,
      S_DONE
   } state_t;

   // Delay chain: tap[c][0] is din registered once, tap[c][k] is din k+1 cycles old.
   logic [W-1:0]  tap    [CH][MAXD];
   logic [W-1:0]  sel    [CH];
   logic [DW-1:0] dly    [CH];

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CH-1:0] seen;
   logic [CH-1:0] prev;
   logic [CW-1:0] t      [CH];
   logic [DW-1:0] newd   [CH];

   logic [CH-1:0] mark;
   logic [CH-1:0] rise;
   logic [CH-1:0] hit;
   logic [CH-1:0] seen_nx;
   logic [CW-1:0] tmax;
   logic [CW-1:0] tmin;

   // Skew between first and last lane must fit in the delay line.
   function automatic logic skew_in_range(input logic [CW-1:0] hi,
                                          input logic [CW-1:0] lo);
      return (hi - lo) <= CW'(MAXD);
   endfunction

   // A lane that saw the marker early waits for the latest lane; the
   // difference always fits in DW once skew_in_range holds.
   function automatic logic [DW-1:0] lane_delay(input logic [CW-1:0] hi,
                                                input logic [CW-1:0] ti);
      return DW'(hi - ti);
   endfunction

   // ---- stage: delay line and output select --------------------------------
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         sel[c] = din[c*W +: W];
         for (int k = 1; k <= MAXD; k++) begin
            if (dly[c] == DW'(k)) sel[c] = tap[c][k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < MAXD; k++) tap[c][k] <= '0;
         end
         dout <= '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            tap[c][0] <= din[c*W +: W];
            for (int k = 1; k < MAXD; k++) tap[c][k] <= tap[c][k-1];
            dout[c*W +: W] <= sel[c];
         end
      end
   end

   // ---- stage: marker edge detect and skew arithmetic ----------------------
   always_comb begin
      for (int c = 0; c < CH; c++) mark[c] = tap[c][0][0];
      rise    = mark & ~prev;
      hit     = rise & ~seen;
      seen_nx = seen | rise;
      tmax    = '0;
      tmin    = '1;
      for (int c = 0; c < CH; c++) begin
         if (t[c] > tmax) tmax = t[c];
         if (t[c] < tmin) tmin = t[c];
      end
   end

   always_comb begin
      skew_out = '0;
      for (int c = 0; c < CH; c++) skew_out[c*DW +: DW] = dly[c];
   end

   // ---- stage: calibration FSM ----------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         seen     <= '0;
         prev     <= '0;
         cal_busy <= 1'b0;
         cal_done <= 1'b0;
         cal_err  <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            t[c]    <= '0;
            newd[c] <= '0;
            dly[c]  <= '0;
         end
      end else begin
         cal_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cal_start) begin
                  state    <= S_ARM;
                  cal_err  <= 1'b0;
                  cal_busy <= 1'b1;
               end
            end
            S_ARM: begin
               seen  <= '0;
               cnt   <= '0;
               prev  <= mark;
               for (int c = 0; c < CH; c++) t[c] <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               prev <= mark;
               seen <= seen_nx;
               for (int c = 0; c < CH; c++) begin
                  if (hit[c]) t[c] <= cnt;
               end
               // A last edge landing exactly on the timeout cycle still counts.
               if (&seen_nx) begin
                  state <= S_CALC;
               end else if (cnt == CW'(TIMEOUT)) begin
                  state    <= S_DONE;
                  cal_busy <= 1'b0;
                  cal_done <= 1'b1;
                  cal_err  <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_CALC: begin
               for (int c = 0; c < CH; c++) newd[c] <= lane_delay(tmax, t[c]);
               state    <= S_DONE;
               cal_busy <= 1'b0;
               cal_done <= 1'b1;
               cal_err  <= ~skew_in_range(tmax, tmin);
            end
            S_DONE: begin
               // On error the previously applied delays stay in place.
               if (!cal_err) begin
                  for (int c = 0; c < CH; c++) dly[c] <= newd[c];
               end
               state <= S_IDLE;
            end
            default: begin
               state    <= S_IDLE;
               cal_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_skew_align.sv
module tb_skew_align;

   localparam int CH      = 4;
   localparam int W       = 1;
   localparam int MAXD    = 7;
   localparam int TIMEOUT = 255;
   localparam int DW      = 3;

   logic              clk;
   logic              rst;
   logic [CH*W-1:0]   din;
   logic              cal_start;
   logic [CH*W-1:0]   dout;
   logic              cal_busy;
   logic              cal_done;
   logic              cal_err;
   logic [CH*DW-1:0]  skew_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model of the delay lines: hist[k] = din sampled k+1 edges ago.
   logic [CH-1:0] hist   [MAXD];
   logic [DW-1:0] mdl_d  [CH];
   logic [DW-1:0] pend_d [CH];
   logic          pend;
   logic [CH-1:0] sb [$];
   logic [CH*DW-1:0] cur_skew;

   typedef struct {
      logic          r;
      logic          cs;
      logic [3:0]    d;
      logic [3:0]    edout;
      logic          ebusy;
      logic          edone;
      logic          eerr;
      logic [11:0]   eskew;
   } vec_t;

   vec_t tbl [7];

   skew_align #(
      .CH(CH), .W(W), .MAXD(MAXD), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .cal_start(cal_start),
      .dout(dout),
      .cal_busy(cal_busy),
      .cal_done(cal_done),
      .cal_err(cal_err),
      .skew_out(skew_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, queue the expected dout, step, then compare.
   task automatic cyc(input logic [CH-1:0] d, input logic cs, input logic r);
      logic [CH-1:0] e;
      logic [CH-1:0] exp_q;
      din       = d;
      cal_start = cs;
      rst       = r;
      e = '0;
      if (!r) begin
         for (int c = 0; c < CH; c++) begin
            if (mdl_d[c] == 0) e[c] = d[c];
            else               e[c] = hist[int'(mdl_d[c]) - 1][c];
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (r) begin
         for (int k = 0; k < MAXD; k++) hist[k] = '0;
         for (int c = 0; c < CH; c++) mdl_d[c] = '0;
         pend = 1'b0;
      end else begin
         for (int k = MAXD - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = d;
         if (pend) begin
            for (int c = 0; c < CH; c++) mdl_d[c] = pend_d[c];
            pend = 1'b0;
         end
      end
      exp_q = sb.pop_front();
      chk("dout", dout, exp_q);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0);
   endtask

   // Calibration run. e_i = WAIT count of lane i's marker edge (-1 = never).
   // inj 1 = extra cal_start at cycle inj_j, inj 2 = reset at cycle inj_j.
   task automatic cal_run(input string nm,
                          input int e0, input int e1, input int e2, input int e3,
                          input logic [CH-1:0] glitch,
                          input int inj, input int inj_j,
                          input int exp_j, input logic exp_err,
                          input logic [CH*DW-1:0] exp_skew);
      int e [CH];
      int done_j;
      logic [CH-1:0] d;
      logic [CH*DW-1:0] prev_skew;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      done_j = -1;
      d = '0;
      prev_skew = cur_skew;
      for (int j = 0; j < TIMEOUT + 40; j++) begin
         for (int c = 0; c < CH; c++)
            d[c] = (e[c] >= 0) && (j >= e[c] + 1) && !(glitch[c] && (j == e[c] + 2));
         cyc(d, (j == 0) || (inj == 1 && j == inj_j), (inj == 2 && j == inj_j));
         if (j == 0) begin
            chk({nm, " busy_at_arm"}, cal_busy, 1);
            chk({nm, " err_cleared"}, cal_err, 0);
         end
         if (inj == 2 && j == inj_j) begin
            chk({nm, " rst_busy"}, cal_busy, 0);
            chk({nm, " rst_skew"}, skew_out, 0);
            chk({nm, " rst_done"}, cal_done, 0);
            chk({nm, " rst_err"}, cal_err, 0);
            cyc(d, 1'b0, 1'b0);
            chk({nm, " rst_stays_idle"}, cal_busy, 0);
            cur_skew = '0;
            return;
         end
         if (cal_done) begin
            done_j = j;
            break;
         end
      end
      chk({nm, " done_cycle"}, done_j, exp_j);
      if (done_j >= 0) begin
         chk({nm, " err_in_done"}, cal_err, exp_err);
         chk({nm, " busy_in_done"}, cal_busy, 0);
         chk({nm, " skew_in_done"}, skew_out, prev_skew);
         if (!exp_err) begin
            for (int c = 0; c < CH; c++) pend_d[c] = exp_skew[c*DW +: DW];
            pend = 1'b1;
         end
         cyc(d, 1'b0, 1'b0);
         chk({nm, " done_pulse"}, cal_done, 0);
         chk({nm, " skew_after"}, skew_out, exp_skew);
         chk({nm, " err_level"}, cal_err, exp_err);
      end
      cur_skew = exp_skew;
   endtask

   // Step all lanes with the given arrival offsets; aligned lanes must rise together.
   task automatic align(input int e0, input int e1, input int e2, input int e3);
      int e [CH];
      logic [CH-1:0] d;
      int found;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      found = 0;
      idle(MAXD + 1);
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < CH; c++) d[c] = (r >= e[c]);
         cyc(d, 1'b0, 1'b0);
         if (found == 0 && dout != '0) begin
            found = 1;
            chk("align_all_lanes", dout, 4'hF);
         end
      end
      chk("align_found", found, 1);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000};
      tbl[1] = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000};
      tbl[2] = '{1'b0, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 12'h000};
      tbl[3] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000};
      tbl[4] = '{1'b0, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0, 12'h000};
      tbl[5] = '{1'b0, 1'b0, 4'hA, 4'hA, 1'b0, 1'b0, 1'b0, 12'h000};
      tbl[6] = '{1'b0, 1'b0, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0, 12'h000};

      rst = 1'b1;
      cal_start = 1'b0;
      din = '0;
      pend = 1'b0;
      cur_skew = '0;
      for (int k = 0; k < MAXD; k++) hist[k] = '0;
      for (int c = 0; c < CH; c++) begin
         mdl_d[c]  = '0;
         pend_d[c] = '0;
      end

      // Reset state and zero-delay pass-through
      for (int i = 0; i < 7; i++) begin
         cyc(tbl[i].d, tbl[i].cs, tbl[i].r);
         chk($sformatf("vec%0d dout", i), dout, tbl[i].edout);
         chk($sformatf("vec%0d busy", i), cal_busy, tbl[i].ebusy);
         chk($sformatf("vec%0d done", i), cal_done, tbl[i].edone);
         chk($sformatf("vec%0d err", i), cal_err, tbl[i].eerr);
         chk($sformatf("vec%0d skew", i), skew_out, tbl[i].eskew);
      end
      idle(3);

      // Nominal calibration, with a second edge on lane 0 that must be ignored
      cal_run("cal_nominal", 2, 5, 3, 2, 4'b0001, 0, 0, 8, 1'b0, 12'h683);
      align(2, 5, 3, 2);
      idle(3);

      // Skew of 9 exceeds MAXD
      cal_run("cal_range", 0, 9, 4, 4, 4'b0000, 0, 0, 12, 1'b1, 12'h683);
      idle(3);

      // cal_start while in WAIT is ignored
      cal_run("cal_restart", 1, 1, 4, 2, 4'b0000, 1, 3, 7, 1'b0, 12'h41B);
      idle(3);

      // Lane 3 never toggles -> timeout
      cal_run("cal_timeout", 1, 2, 3, -1, 4'b0000, 0, 0, TIMEOUT + 2, 1'b1, 12'h41B);
      idle(3);

      // All lanes together -> all delays zero
      cal_run("cal_same", 3, 3, 3, 3, 4'b1111, 0, 0, 6, 1'b0, 12'h000);
      idle(3);

      // Last edge exactly on the timeout count
      cal_run("cal_edge_at_to", 250, 252, 255, 253, 4'b0000, 0, 0, TIMEOUT + 3, 1'b0, 12'h41D);
      idle(3);

      // Reset in the middle of WAIT
      cal_run("cal_rst", 1, 2, 3, 4, 4'b0000, 2, 3, 0, 1'b0, 12'h000);
      idle(3);

      // Skew exactly MAXD is still in range
      cal_run("cal_maxd", 0, 7, 0, 7, 4'b0000, 0, 0, 10, 1'b0, 12'h1C7);
      align(0, 7, 0, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
